// File: rtl/issue_port_sched_pkg.sv
// Shared types and constants for the issue-port scheduler:
// unit classes, latencies and the writeback slot layout.
package issue_port_sched_pkg;

   localparam int WIDTH_TAG = 5;
   localparam int MUL_LAT   = 3;
   localparam int DIV_LAT   = 8;
   localparam int WB_DEPTH  = 16;
   localparam int IDX_W     = $clog2(WB_DEPTH);
   localparam int CNT_W     = $clog2(DIV_LAT);

   typedef enum logic [1:0] {
      FU_ALU = 2'd0,
      FU_MUL = 2'd1,
      FU_DIV = 2'd2,
      FU_RSV = 2'd3
   } fu_e;

   typedef logic [WIDTH_TAG-1:0] tag_t;
   typedef logic [IDX_W-1:0]     idx_t;

   typedef struct packed {
      logic valid;
      tag_t tag;
   } wb_slot_t;

   function automatic idx_t fu_lat(input fu_e f);
      idx_t l;
      case (f)
         FU_MUL:  l = idx_t'(MUL_LAT);
         FU_DIV:  l = idx_t'(DIV_LAT);
         default: l = idx_t'(1);
      endcase
      return l;
   endfunction

endpackage

// File: rtl/issue_port_sched_if.sv
// Issue-queue / writeback bundle between the queue and the scheduler.
// master = queue side, slave = scheduler.
interface issue_port_sched_if;
   import issue_port_sched_pkg::*;

   logic [1:0] i_req;
   logic [1:0] i_fu0;
   logic [1:0] i_fu1;
   tag_t       i_tag0;
   tag_t       i_tag1;
   logic       i_flush;
   logic [1:0] o_grant;
   logic [1:0] o_wb_valid;
   tag_t       o_wb_tag0;
   tag_t       o_wb_tag1;
   logic       o_div_busy;

   modport master (
      output i_req, i_fu0, i_fu1, i_tag0, i_tag1, i_flush,
      input  o_grant, o_wb_valid, o_wb_tag0, o_wb_tag1, o_div_busy
   );

   modport slave (
      input  i_req, i_fu0, i_fu1, i_tag0, i_tag1, i_flush,
      output o_grant, o_wb_valid, o_wb_tag0, o_wb_tag1, o_div_busy
   );

endinterface

// File: rtl/issue_port_sched_wb_resv_table.sv
// Writeback reservation table: shifts down one entry per cycle,
// two slots per entry, two inserts into the post-shift table.
module wb_resv_table
   import issue_port_sched_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     clr,
   input  idx_t     rd_idx0,
   input  idx_t     rd_idx1,
   output logic [1:0] occ0,
   output logic [1:0] occ1,
   input  logic     we0,
   input  idx_t     widx0,
   input  tag_t     wtag0,
   input  logic     we1,
   input  idx_t     widx1,
   input  tag_t     wtag1,
   output wb_slot_t head0,
   output wb_slot_t head1
);

   wb_slot_t tbl_q [WB_DEPTH][2];
   wb_slot_t tbl_d [WB_DEPTH][2];

   always_comb begin
      for (int d = 0; d < WB_DEPTH; d++) begin
         for (int s = 0; s < 2; s++) begin
            if (d == WB_DEPTH-1) tbl_d[d][s] = '0;
            else                 tbl_d[d][s] = tbl_q[d+1][s];
         end
      end
      // port 0 inserts first so it owns the lower free slot
      if (we0) begin
         if (!tbl_d[widx0][0].valid) tbl_d[widx0][0] = {1'b1, wtag0};
         else                        tbl_d[widx0][1] = {1'b1, wtag0};
      end
      if (we1) begin
         if (!tbl_d[widx1][0].valid) tbl_d[widx1][0] = {1'b1, wtag1};
         else                        tbl_d[widx1][1] = {1'b1, wtag1};
      end
      if (clr) begin
         for (int d = 0; d < WB_DEPTH; d++) begin
            tbl_d[d][0] = '0;
            tbl_d[d][1] = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int d = 0; d < WB_DEPTH; d++) begin
            tbl_q[d][0] <= '0;
            tbl_q[d][1] <= '0;
         end
      end else begin
         tbl_q <= tbl_d;
      end
   end

   assign occ0  = {1'b0, tbl_q[rd_idx0][0].valid}
                + {1'b0, tbl_q[rd_idx0][1].valid};
   assign occ1  = {1'b0, tbl_q[rd_idx1][0].valid}
                + {1'b0, tbl_q[rd_idx1][1].valid};
   assign head0 = tbl_q[0][0];
   assign head1 = tbl_q[0][1];

endmodule

// File: rtl/issue_port_sched.sv
// Dual-port issue scheduler: grants queue heads against MUL/DIV and
// writeback-port hazards, and replays granted tags at writeback.
module issue_port_sched
   import issue_port_sched_pkg::*;
(
   input logic i_clk,
   input logic i_rst,
   issue_port_sched_if.slave bus
);

   fu_e        fu0;
   fu_e        fu1;
   idx_t       lat0;
   idx_t       lat1;
   logic [1:0] occ0;
   logic [1:0] occ1;
   logic [1:0] occ1x;
   logic       blk;
   logic       g0;
   logic       g1;
   wb_slot_t   head0;
   wb_slot_t   head1;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign fu0  = fu_e'(bus.i_fu0);
   assign fu1  = fu_e'(bus.i_fu1);
   assign lat0 = fu_lat(fu0);
   assign lat1 = fu_lat(fu1);
   assign blk  = bus.i_flush | i_rst;

   always_comb begin
      g0    = 1'b0;
      g1    = 1'b0;
      occ1x = occ1;
      cnt_d = cnt_q;
      g0 = bus.i_req[0] && (fu0 != FU_RSV) && (occ0 < 2'd2)
         && !(fu0 == FU_DIV && cnt_q != '0) && !blk;
      // a same-latency port-0 grant consumes one write port too
      occ1x = occ1 + {1'b0, g0 && (lat0 == lat1)};
      g1 = bus.i_req[1] && (fu1 != FU_RSV) && (occ1x < 2'd2)
         && !(fu1 == FU_MUL && g0 && fu0 == FU_MUL)
         && !(fu1 == FU_DIV && (cnt_q != '0 || (g0 && fu0 == FU_DIV)))
         && !blk;
      if (blk)
         cnt_d = '0;
      else if ((g0 && fu0 == FU_DIV) || (g1 && fu1 == FU_DIV))
         cnt_d = CNT_W'(DIV_LAT - 1);
      else if (cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   wb_resv_table u_tbl (
      .clk     (i_clk),
      .rst     (i_rst),
      .clr     (bus.i_flush),
      .rd_idx0 (lat0),
      .rd_idx1 (lat1),
      .occ0    (occ0),
      .occ1    (occ1),
      .we0     (g0),
      .widx0   (lat0 - idx_t'(1)),
      .wtag0   (bus.i_tag0),
      .we1     (g1),
      .widx1   (lat1 - idx_t'(1)),
      .wtag1   (bus.i_tag1),
      .head0   (head0),
      .head1   (head1)
   );

   assign bus.o_grant    = {g1, g0};
   assign bus.o_wb_valid = blk ? 2'b00 : {head1.valid, head0.valid};
   assign bus.o_wb_tag0  = i_rst ? '0 : head0.tag;
   assign bus.o_wb_tag1  = i_rst ? '0 : head1.tag;
   assign bus.o_div_busy = !i_rst && (cnt_q != '0);

endmodule
